// File: rtl/pipe_ctrl.sv
// Stall vector generation and multi-cycle EX sequencer for the five-stage core.
// The sequencer counts EX occupancy and pulses mc_done when a multi-cycle result is final.
module pipe_ctrl #(
    parameter int CNT_W  = 6,
    parameter int STAT_W = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              stallreq_id,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_len,
    input  logic              mc_abort,
    output logic [5:0]        stall,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  mc_cnt,
    output logic              mc_done,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, len_nxt, cnt_nxt, len_eff;
    logic             ex_req;

    // A zero length still costs one stall cycle.
    assign len_eff = (mc_len == '0) ? CNT_ONE : mc_len;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            mc_cnt <= '0;
            len_q  <= CNT_ONE;
        end else begin
            state  <= state_nxt;
            mc_cnt <= cnt_nxt;
            len_q  <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = mc_cnt;
        len_nxt   = len_q;
        if (mc_abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        len_nxt   = len_eff;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = (len_eff == CNT_ONE) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (mc_cnt == len_q - CNT_ONE) begin
                        state_nxt = DONE;
                        cnt_nxt   = len_q;
                    end else begin
                        cnt_nxt = mc_cnt + CNT_ONE;
                    end
                end
                // The instruction still showing mc_start leaves EX at this edge.
                DONE: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign ex_req  = ~mc_abort & (((state == IDLE) & mc_start) | (state == RUN));
    assign mc_busy = (state != IDLE);
    assign mc_done = (state == DONE);

    always_comb begin
        stall = 6'b000000;
        if (!Rst_n) begin
            stall = 6'b000000;
        end else if (ex_req) begin
            stall = 6'b001111;
        end else if (stallreq_id && !mc_abort) begin
            stall = 6'b000111;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt <= '0;
        end else if (stall[0] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STAT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_pipe_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        stallreq_id;
    logic        mc_start;
    logic [5:0]  mc_len;
    logic        mc_abort;

    logic [5:0]  stall, stall2;
    logic        mc_busy, mc_busy2;
    logic [5:0]  mc_cnt, mc_cnt2;
    logic        mc_done, mc_done2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    typedef struct {
        logic [5:0]  stall;
        logic        busy;
        logic [5:0]  cnt;
        logic        done;
        logic [15:0] scnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    pipe_ctrl #(.CNT_W(6), .STAT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .stallreq_id(stallreq_id), .mc_start(mc_start),
        .mc_len(mc_len), .mc_abort(mc_abort), .stall(stall), .mc_busy(mc_busy),
        .mc_cnt(mc_cnt), .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(6), .STAT_W(2)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .stallreq_id(stallreq_id), .mc_start(mc_start),
        .mc_len(mc_len), .mc_abort(mc_abort), .stall(stall2), .mc_busy(mc_busy2),
        .mc_cnt(mc_cnt2), .mc_done(mc_done2), .stall_cnt(stall_cnt2)
    );

    always #5 Clk = ~Clk;

    task automatic vec(input logic rst, input logic sreq, input logic start,
                       input logic [5:0] len, input logic abort,
                       input logic [5:0] e_stall, input logic e_busy,
                       input logic [5:0] e_cnt, input logic e_done,
                       input logic [15:0] e_scnt);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n       = rst;
        stallreq_id = sreq;
        mc_start    = start;
        mc_len      = len;
        mc_abort    = abort;
        e.stall = e_stall;
        e.busy  = e_busy;
        e.cnt   = e_cnt;
        e.done  = e_done;
        e.scnt  = e_scnt;
        q.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [1:0] e_sat;
            e     = q.pop_front();
            e_sat = (e.scnt > 16'd3) ? 2'd3 : e.scnt[1:0];
            n_vec++;
            if (stall !== e.stall || mc_busy !== e.busy || mc_cnt !== e.cnt ||
                mc_done !== e.done || stall_cnt !== e.scnt ||
                stall2 !== e.stall || mc_busy2 !== e.busy || mc_cnt2 !== e.cnt ||
                mc_done2 !== e.done || stall_cnt2 !== e_sat) begin
                n_bad++;
                $display("FAIL vec%0d: got stall=%b busy=%b cnt=%0d done=%b scnt=%0d | w2: stall=%b busy=%b cnt=%0d done=%b scnt=%0d ; want stall=%b busy=%b cnt=%0d done=%b scnt=%0d scnt_w2=%0d",
                         n_vec, stall, mc_busy, mc_cnt, mc_done, stall_cnt,
                         stall2, mc_busy2, mc_cnt2, mc_done2, stall_cnt2,
                         e.stall, e.busy, e.cnt, e.done, e.scnt, e_sat);
            end
        end
    end

    initial begin
        Rst_n       = 1'b0;
        stallreq_id = 1'b1;
        mc_start    = 1'b1;
        mc_len      = 6'd4;
        mc_abort    = 1'b0;

        // reset held with requests active
        vec(0, 1, 1, 4, 0, 6'b000000, 0, 0, 0, 0);
        vec(0, 1, 1, 4, 0, 6'b000000, 0, 0, 0, 0);
        // release with mc_start still high: accepted as a new op
        vec(1, 1, 1, 4, 0, 6'b001111, 0, 0, 0, 0);
        vec(1, 0, 1, 4, 0, 6'b001111, 1, 1, 0, 1);
        // asynchronous reset mid-op clears everything immediately
        vec(0, 0, 1, 4, 0, 6'b000000, 0, 0, 0, 0);
        vec(0, 0, 0, 4, 0, 6'b000000, 0, 0, 0, 0);
        vec(1, 0, 0, 4, 0, 6'b000000, 0, 0, 0, 0);

        // single ID hazard pulse
        vec(1, 1, 0, 4, 0, 6'b000111, 0, 0, 0, 0);
        vec(1, 0, 0, 4, 0, 6'b000000, 0, 0, 0, 1);

        // mc_len=4, later mc_len changes ignored
        vec(1, 0, 1, 4, 0, 6'b001111, 0, 0, 0, 1);
        vec(1, 0, 1, 7, 0, 6'b001111, 1, 1, 0, 2);
        vec(1, 0, 1, 7, 0, 6'b001111, 1, 2, 0, 3);
        vec(1, 0, 1, 7, 0, 6'b001111, 1, 3, 0, 4);
        vec(1, 0, 1, 7, 0, 6'b000000, 1, 4, 1, 5);
        vec(1, 0, 0, 7, 0, 6'b000000, 0, 0, 0, 5);

        // mc_len=0, then mc_len=1 back-to-back, ID request during DONE
        vec(1, 0, 1, 0, 0, 6'b001111, 0, 0, 0, 5);
        vec(1, 0, 1, 0, 0, 6'b000000, 1, 1, 1, 6);
        vec(1, 0, 1, 1, 0, 6'b001111, 0, 0, 0, 6);
        vec(1, 1, 1, 1, 0, 6'b000111, 1, 1, 1, 7);
        vec(1, 0, 0, 1, 0, 6'b000000, 0, 0, 0, 8);

        // mc_len=32 with ID request held, abort at count 10
        vec(1, 1, 1, 32, 0, 6'b001111, 0, 0, 0, 8);
        for (int k = 1; k <= 9; k++)
            vec(1, 1, 1, 32, 0, 6'b001111, 1, 6'(k), 0, 16'(8 + k));
        vec(1, 1, 1, 32, 1, 6'b000000, 1, 10, 0, 18);
        vec(1, 1, 0, 32, 0, 6'b000111, 0, 0, 0, 18);
        vec(1, 1, 0, 32, 0, 6'b000111, 0, 0, 0, 19);
        vec(1, 0, 0, 32, 0, 6'b000000, 0, 0, 0, 20);
        // abort in IDLE blocks acceptance and the ID stall
        vec(1, 1, 1, 5, 1, 6'b000000, 0, 0, 0, 20);
        vec(1, 0, 0, 5, 0, 6'b000000, 0, 0, 0, 20);

        // back-to-back ops of length 2 then 3
        vec(1, 0, 1, 2, 0, 6'b001111, 0, 0, 0, 20);
        vec(1, 0, 1, 9, 0, 6'b001111, 1, 1, 0, 21);
        vec(1, 0, 1, 3, 0, 6'b000000, 1, 2, 1, 22);
        vec(1, 0, 1, 3, 0, 6'b001111, 0, 0, 0, 22);
        vec(1, 0, 1, 3, 0, 6'b001111, 1, 1, 0, 23);
        vec(1, 0, 1, 3, 0, 6'b001111, 1, 2, 0, 24);
        vec(1, 0, 1, 3, 0, 6'b000000, 1, 3, 1, 25);
        vec(1, 0, 0, 3, 0, 6'b000000, 0, 0, 0, 25);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge Clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
